// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues word fetches to a 1-cycle instruction
// memory, buffers returned words with their PCs in a small FIFO and hands
// them to decode through a valid/ready handshake. A taken branch/jump from
// EX flushes every piece of wrong-path state in the cycle it is signalled.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ImemReq,
    output logic [31:0]                ImemAddr,
    input  logic                       ImemRvalid,
    input  logic [31:0]                ImemRdata,
    input  logic                       PCSrcE,
    input  logic [31:0]                PCTargetE,
    output logic                       ValidD,
    input  logic                       ReadyD,
    output logic [31:0]                InstrD,
    output logic [31:0]                PCD,
    output logic [31:0]                PCPlus4D,
    output logic [$clog2(DEPTH):0]     QCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pcf_q, pcf_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic          inflight_q, inflight_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic          pop, push;
    logic [CW:0]   occ_next;

    // Handshake and request decision; a request is only made if its response
    // is guaranteed a free slot, so the FIFO can never overflow.
    always_comb begin
        ValidD   = (count_q != '0) & ~PCSrcE & ~reset;
        pop      = ValidD & ReadyD;
        push     = ImemRvalid & ~PCSrcE & ~reset;
        occ_next = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        ImemReq  = ~reset & ~PCSrcE & (occ_next < (CW+1)'(DEPTH));
        ImemAddr = pcf_q;
    end

    // Head-of-queue presentation; idle outputs look like a NOP at PC 0.
    always_comb begin
        InstrD   = ValidD ? instr_mem_q[rd_ptr_q] : NOP;
        PCD      = ValidD ? pc_mem_q[rd_ptr_q] : 32'h0;
        PCPlus4D = PCD + 32'd4;
        QCount   = count_q;
    end

    // Next-state for PC, pointers and occupancy; redirect discards everything.
    always_comb begin
        pcf_d      = pcf_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = ImemReq;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (PCSrcE) begin
            pcf_d    = {PCTargetE[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (ImemReq) begin
                pcf_d     = pcf_q + 32'd4;
                resp_pc_d = pcf_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register; reset overrides a simultaneous redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q      <= RESET_PC;
            resp_pc_q  <= 32'h0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pcf_q      <= pcf_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= ImemRdata;
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a 1-cycle memory responder plus a queue-based
// reference model of the fetch stage, driven by directed and random traffic.
module tb_instr_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset, ImemReq, ImemRvalid, PCSrcE, ValidD, ReadyD;
    logic [31:0] ImemAddr, ImemRdata, PCTargetE, InstrD, PCD, PCPlus4D;
    logic [$clog2(DEPTH):0] QCount;

    instr_fetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .ValidD(ValidD), .ReadyD(ReadyD),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .QCount(QCount)
    );

    always #5 clk = ~clk;

    // Instruction memory: data = addr ^ KEY, answered one cycle after request.
    initial ImemRvalid = 1'b0;
    always @(posedge clk) begin
        ImemRvalid <= ImemReq;
        ImemRdata  <= ImemAddr ^ KEY;
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: PC, outstanding fetch address, FIFO of {instr, pc}.
    logic [31:0] m_pc;
    logic        m_infl;
    logic [31:0] m_infl_addr;
    logic [63:0] m_q[$];
    bit          m_init = 0;

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic step(input bit rst, input bit rdy, input bit src, input logic [31:0] tgt);
        bit e_valid, e_pop, e_req;
        logic [31:0] e_instr, e_pc;
        int occ;
        @(negedge clk);
        reset = rst; ReadyD = rdy; PCSrcE = src; PCTargetE = tgt;
        #1;
        e_valid = m_init && (m_q.size() != 0) && !src && !rst;
        e_pop   = e_valid && rdy;
        occ     = m_q.size() + int'(m_infl) - int'(e_pop);
        e_req   = !rst && !src && m_init && (occ < DEPTH);
        e_instr = e_valid ? m_q[0][63:32] : 32'h0000_0013;
        e_pc    = e_valid ? m_q[0][31:0]  : 32'h0;
        chk("ImemReq", 32'(ImemReq), 32'(e_req));
        chk("ValidD", 32'(ValidD), 32'(e_valid));
        chk("InstrD", InstrD, e_instr);
        chk("PCD", PCD, e_pc);
        chk("PCPlus4D", PCPlus4D, e_pc + 32'd4);
        if (m_init) begin
            chk("ImemAddr", ImemAddr, m_pc);
            chk("QCount", 32'(QCount), 32'(m_q.size()));
        end
        if (rst) begin
            m_pc = RPC; m_q.delete(); m_infl = 0; m_init = 1;
        end else if (src) begin
            m_pc = {tgt[31:2], 2'b00}; m_q.delete(); m_infl = 0;
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back({m_infl_addr ^ KEY, m_infl_addr});
            m_infl = e_req;
            if (e_req) begin
                m_infl_addr = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        bit hit;
        reset = 1'b1; ReadyD = 1'b1; PCSrcE = 1'b0; PCTargetE = '0;

        // Reset then streaming from RESET_PC
        step(1, 1, 0, 0); step(1, 1, 0, 0);
        chk("rst_qcount", 32'(QCount), 32'd0);
        chk("rst_pcp4", PCPlus4D, 32'd4);
        repeat (12) step(0, 1, 0, 0);

        // Stall decode: queue fills to DEPTH and fetch stops
        repeat (10) step(0, 0, 0, 0);
        chk("full_qcount", 32'(QCount), DEPTH);
        chk("full_req", 32'(ImemReq), 32'd0);
        repeat (10) step(0, 1, 0, 0);

        // Redirect to 0x100 while PCD == 8
        step(1, 1, 0, 0);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(0, 1, 0, 0);
            if (m_q.size() != 0 && m_q[0][31:0] == 32'h8) hit = 1;
        end
        chk("reach_pc8", 32'(hit), 32'd1);
        step(0, 1, 1, 32'h100);
        chk("redir_valid", 32'(ValidD), 32'd0);
        step(0, 1, 0, 0);
        chk("redir_addr", ImemAddr, 32'h100);
        chk("redir_qcount", 32'(QCount), 32'd0);
        repeat (2) step(0, 1, 0, 0);
        chk("redir_pcd", PCD, 32'h100);
        repeat (4) step(0, 1, 0, 0);

        // Misaligned target is aligned
        step(0, 1, 1, 32'h103);
        step(0, 1, 0, 0);
        chk("align_addr", ImemAddr, 32'h100);
        repeat (6) step(0, 1, 0, 0);

        // PC wrap at the top of the address space
        step(0, 1, 1, 32'hFFFF_FFF8);
        repeat (8) step(0, 1, 0, 0);

        // Full queue then one-cycle reset
        repeat (8) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_instr", InstrD, 32'h0000_0013);
        step(0, 1, 0, 0);
        chk("rst_next_addr", ImemAddr, RPC);
        chk("rst_next_q", 32'(QCount), 32'd0);
        repeat (6) step(0, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit r, s, d;
            r = ($urandom_range(99) == 0);
            s = ($urandom_range(11) == 0);
            d = ($urandom_range(9) < 7);
            step(r, d, s, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
